q_update: RTL and testbench

- Downstream consumer of the state/action/Q-value delay stages in the Q-learning datapath.
- Takes the delayed (state, action, Q_old) triple together with the reward and max next-state Q.
- Computes Q_new = Q_old + alpha*(R + gamma*maxQ' - Q_old) using shift-only arithmetic.
- Emits a registered Q-RAM write (address, data, write-enable) after a fixed 3-cycle pipeline.

---
 rtl/q_update.sv | 178 +++++++++++++++++
 tb/tb_q_update.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/q_update.sv
// q_update: Q-learning table update stage.
// Computes Q_new = Q_old + alpha*(R + gamma*maxQ' - Q_old) with shift-only
// arithmetic (alpha = 2^-ALPHA_SHIFT, gamma = 1 - 2^-GAMMA_SHIFT) and issues a
// registered Q-RAM write three cycles after the input is accepted.
// Build option: define Q_UPDATE_SAT_EN to saturate Q_new to the signed QW range;
// without it Q_new wraps to its low QW bits.
module q_update #(
    parameter int unsigned QW          = 16,
    parameter int unsigned SW          = 6,
    parameter int unsigned AW          = 4,
    parameter int unsigned ALPHA_SHIFT = 2,
    parameter int unsigned GAMMA_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [SW-1:0]    in_state,
    input  logic [AW-1:0]    in_action,
    input  logic [QW-1:0]    in_qold,
    input  logic [QW-1:0]    in_reward,
    input  logic [QW-1:0]    in_maxq,
    output logic             wr_en,
    output logic [SW+AW-1:0] wr_addr,
    output logic [QW-1:0]    wr_data,
    output logic             hazard,
    output logic [15:0]      upd_count
);

    // Internal arithmetic carries two guard bits above the Q-value width.
    localparam int unsigned IW  = QW + 2;
    localparam int unsigned ADW = SW + AW;
    localparam int unsigned CW  = 16;
    localparam logic [CW-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic                 s1_valid;
    logic [ADW-1:0]       s1_addr;
    logic [QW-1:0]        s1_qold;
    logic signed [IW-1:0] s1_target;

    logic                 s2_valid;
    logic [ADW-1:0]       s2_addr;
    logic [QW-1:0]        s2_qold;
    logic signed [IW-1:0] s2_delta;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [ADW-1:0]       in_addr_c;
    logic signed [IW-1:0] maxq_ext_c;
    logic signed [IW-1:0] reward_ext_c;
    logic signed [IW-1:0] gamma_q_c;
    logic signed [IW-1:0] target_c;
    logic signed [IW-1:0] s1_qold_ext_c;
    logic signed [IW-1:0] td_c;
    logic signed [IW-1:0] delta_c;
    logic signed [IW-1:0] s2_qold_ext_c;
    logic [QW-1:0]        wr_data_next_c;
    logic                 hazard_hit_c;

    // Input address and sign-extended operands.
    assign in_addr_c    = {in_state, in_action};
    assign maxq_ext_c   = {{(IW-QW){in_maxq[QW-1]}}, in_maxq};
    assign reward_ext_c = {{(IW-QW){in_reward[QW-1]}}, in_reward};

    // gamma*maxQ' as maxQ' minus its arithmetic-shifted copy, then add reward.
    assign gamma_q_c = maxq_ext_c - (maxq_ext_c >>> GAMMA_SHIFT);
    assign target_c  = reward_ext_c + gamma_q_c;

    // Temporal difference scaled by alpha (floor toward -inf).
    assign s1_qold_ext_c = {{(IW-QW){s1_qold[QW-1]}}, s1_qold};
    assign td_c          = s1_target - s1_qold_ext_c;
    assign delta_c       = td_c >>> ALPHA_SHIFT;

    assign s2_qold_ext_c = {{(IW-QW){s2_qold[QW-1]}}, s2_qold};

`ifdef Q_UPDATE_SAT_EN
    localparam logic signed [IW-1:0] QMAX = {{(IW-QW+1){1'b0}}, {(QW-1){1'b1}}};
    localparam logic signed [IW-1:0] QMIN = {{(IW-QW+1){1'b1}}, {(QW-1){1'b0}}};

    logic signed [IW-1:0] sum_full_c;

    assign sum_full_c = s2_qold_ext_c + s2_delta;

    // Clamp the updated value to the representable signed QW range.
    always_comb begin
        wr_data_next_c = sum_full_c[QW-1:0];
        if (sum_full_c > QMAX) begin
            wr_data_next_c = {1'b0, {(QW-1){1'b1}}};
        end else if (sum_full_c < QMIN) begin
            wr_data_next_c = {1'b1, {(QW-1){1'b0}}};
        end
    end
`else
    // Two's-complement wrap of the updated value to QW bits.
    assign wr_data_next_c = QW'(s2_qold_ext_c + s2_delta);
`endif

    // Read-after-write hazard: accepted address already held by a live stage.
    assign hazard_hit_c = in_valid &&
                          ((s1_valid && (s1_addr == in_addr_c)) ||
                           (s2_valid && (s2_addr == in_addr_c)) ||
                           (wr_en    && (wr_addr == in_addr_c)));

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // S1: capture target, old Q and address of an accepted input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_qold   <= '0;
            s1_target <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_addr   <= in_addr_c;
                s1_qold   <= in_qold;
                s1_target <= target_c;
            end
        end
    end

    // S2: hold alpha-scaled delta alongside old Q and address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_qold  <= '0;
            s2_delta <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_addr  <= s1_addr;
                s2_qold  <= s1_qold;
                s2_delta <= delta_c;
            end
        end
    end

    // S3: Q-RAM write port; address/data hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= s2_valid;
            if (s2_valid) begin
                wr_addr <= s2_addr;
                wr_data <= wr_data_next_c;
            end
        end
    end

    // Single-cycle hazard pulse for the upstream controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazard <= 1'b0;
        end else begin
            hazard <= hazard_hit_c;
        end
    end

    // Saturating count of committed writes, in step with wr_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_count <= '0;
        end else if (s2_valid && (upd_count != CNT_MAX)) begin
            upd_count <= upd_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_q_update.sv
// tb_q_update: directed and randomized checks of q_update against an
// arithmetic reference of the Q-learning update rule.
module tb_q_update;

    localparam int GDIV = 1 << 3;   // 2^GAMMA_SHIFT
    localparam int ADIV = 1 << 2;   // 2^ALPHA_SHIFT

    typedef struct packed {
        logic        v;
        logic [9:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [5:0]  in_state;
    logic [3:0]  in_action;
    logic [15:0] in_qold;
    logic [15:0] in_reward;
    logic [15:0] in_maxq;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        hazard;
    logic [15:0] upd_count;

    int checks;
    int errors;

    // Reference state: writes expected per sample, last committed write, counter.
    exp_t        pipe[$];
    logic [9:0]  last_addr;
    logic [15:0] last_data;
    logic [15:0] mcount;
    logic        exp_hazard;

    q_update dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_state  (in_state),
        .in_action (in_action),
        .in_qold   (in_qold),
        .in_reward (in_reward),
        .in_maxq   (in_maxq),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .hazard    (hazard),
        .upd_count (upd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    function automatic int fdiv(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    // Q_new from the update rule in plain integer arithmetic.
    function automatic logic [15:0] qnew(input logic [15:0] qo, input logic [15:0] r,
                                         input logic [15:0] m);
        int iq, ir, im, g, delta, sum;
        iq    = int'($signed(qo));
        ir    = int'($signed(r));
        im    = int'($signed(m));
        g     = im - fdiv(im, GDIV);
        delta = fdiv(ir + g - iq, ADIV);
        sum   = iq + delta;
`ifdef Q_UPDATE_SAT_EN
        if (sum > 32767) return 16'h7FFF;
        if (sum < -32768) return 16'h8000;
`endif
        return 16'(sum);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_t b;
        b = '0;
        pipe.delete();
        repeat (3) pipe.push_back(b);
        last_addr  = '0;
        last_data  = '0;
        mcount     = '0;
        exp_hazard = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_wr_en"},   wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_hazard"},  hazard, 0);
        chk({tag, "_count"},   upd_count, 0);
    endtask

    // One clock: check outputs against the reference, then drive the next input.
    task automatic step(input logic v, input logic [5:0] s, input logic [3:0] a,
                        input logic [15:0] qo, input logic [15:0] r, input logic [15:0] m);
        exp_t e;
        exp_t n;
        logic [9:0] ad;
        @(posedge clk);
        #1;
        e = pipe.pop_front();
        if (e.v) begin
            last_addr = e.addr;
            last_data = e.data;
            if (mcount != 16'hFFFF) mcount = mcount + 16'd1;
        end
        chk("wr_en",     wr_en, e.v);
        chk("wr_addr",   wr_addr, last_addr);
        chk("wr_data",   wr_data, last_data);
        chk("hazard",    hazard, exp_hazard);
        chk("upd_count", upd_count, mcount);
        ad = {s, a};
        exp_hazard = v && ((e.v && e.addr == ad) ||
                           (pipe[0].v && pipe[0].addr == ad) ||
                           (pipe[1].v && pipe[1].addr == ad));
        in_valid  = v;
        in_state  = s;
        in_action = a;
        in_qold   = qo;
        in_reward = r;
        in_maxq   = m;
        n.v    = v;
        n.addr = ad;
        n.data = qnew(qo, r, m);
        pipe.push_back(n);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 4'd0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic rand_step(input int valid_pct, input int addr_max);
        step(($urandom_range(0, 99) < valid_pct) ? 1'b1 : 1'b0,
             6'($urandom_range(0, addr_max)), 4'($urandom_range(0, addr_max)),
             16'($urandom), 16'($urandom), 16'($urandom));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_action = '0;
        in_qold   = '0;
        in_reward = '0;
        in_maxq   = '0;
        model_reset();

        // Power-on reset.
        #3 rst_n = 1'b0;
        #1 chk_cleared("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic update: 1.0 + 0.25*(1.0 + 0.875*2.0 - 1.0) = 0x0170.
        step(1'b1, 6'd9, 4'd5, 16'h0100, 16'h0100, 16'h0200);
        idle(3);
        chk("basic_wr_en",   wr_en, 1);
        chk("basic_wr_data", wr_data, 16'h0170);
        chk("basic_wr_addr", wr_addr, {6'd9, 4'd5});
        chk("basic_count",   upd_count, 1);

        // Negative reward rounds toward -inf.
        step(1'b1, 6'd3, 4'd2, 16'h0000, 16'hFF00, 16'h0000);
        idle(3);
        chk("neg_wr_data", wr_data, 16'hFFC0);

        // Overflow of the signed range.
        step(1'b1, 6'd63, 4'd15, 16'h7F00, 16'h7FFF, 16'h7FFF);
        idle(3);
`ifdef Q_UPDATE_SAT_EN
        chk("ovf_wr_data", wr_data, 16'h7FFF);
`else
        chk("ovf_wr_data", wr_data, 16'h9B3F);
`endif
        idle(2);
        chk("hold_wr_en", wr_en, 0);

        // Five distinct back-to-back writes, then a repeat of the last address.
        for (int i = 1; i <= 5; i++)
            step(1'b1, 6'(i), 4'(i), 16'(i * 16'h0100), 16'h0040, 16'(16'h0300 - i));
        step(1'b1, 6'd5, 4'd5, 16'h0010, 16'h0020, 16'h0030);
        step(1'b0, 6'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        chk("hazard_pulse", hazard, 1);
        step(1'b0, 6'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        chk("hazard_drop", hazard, 0);
        idle(3);

        // Mid-stream reset with two updates in flight.
        step(1'b1, 6'd20, 4'd1, 16'h0200, 16'h0100, 16'h0100);
        step(1'b1, 6'd21, 4'd2, 16'h0300, 16'h0100, 16'h0100);
        step(1'b0, 6'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        #2 rst_n = 1'b0;
        #1 chk_cleared("mid_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_cleared("rst_hold");
        rst_n = 1'b1;
        idle(4);
        step(1'b1, 6'd7, 4'd7, 16'h0100, 16'h0100, 16'h0200);
        idle(3);
        chk("post_rst_count", upd_count, 1);

        // Randomized traffic on a small address space to provoke hazards.
        for (int i = 0; i < 400; i++) rand_step(70, 3);
        for (int i = 0; i < 200; i++) rand_step(100, 1);

        // Counter saturation: enough writes to pass 0xFFFF.
        for (int i = 0; i < 65540; i++) rand_step(100, 15);
        idle(4);
        chk("count_sat", upd_count, 16'hFFFF);
        idle(2);
        chk("count_hold", upd_count, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
